// File: rtl/bus_sys_onchip_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bus_sys_onchip_mem_arbiter
// Purpose  : Shares one single-port on-chip RAM (registered-address read,
//            one cycle latency) between two Avalon-MM requesters. Grants are
//            round-robin or fixed-priority, with an optional burst lock, a
//            starvation cap, a pipelined read return and out-of-range
//            trapping.
// Revision : 1.0  initial release
// ============================================================================
module bus_sys_onchip_mem_arbiter #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 38400,
    parameter int FIXED_PRI = 0,
    parameter int MAX_HOLD  = 16,
    localparam int BE_W     = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset,

    input  logic [ADDR_W-1:0] s0_address,
    input  logic              s0_read,
    input  logic              s0_write,
    input  logic [DATA_W-1:0] s0_writedata,
    input  logic [BE_W-1:0]   s0_byteenable,
    input  logic              s0_lock,
    output logic              s0_waitrequest,
    output logic [DATA_W-1:0] s0_readdata,
    output logic              s0_readdatavalid,

    input  logic [ADDR_W-1:0] s1_address,
    input  logic              s1_read,
    input  logic              s1_write,
    input  logic [DATA_W-1:0] s1_writedata,
    input  logic [BE_W-1:0]   s1_byteenable,
    input  logic              s1_lock,
    output logic              s1_waitrequest,
    output logic [DATA_W-1:0] s1_readdata,
    output logic              s1_readdatavalid,

    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    output logic [BE_W-1:0]   mem_byteenable,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata,

    output logic              err_oor
);

    localparam int                HOLD_W      = $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] c_max_hold  = HOLD_W'(MAX_HOLD);
    localparam logic [ADDR_W:0]   c_depth_ext = (ADDR_W + 1)'(DEPTH);

    // Arbitration state: port 0 = s0, port 1 = s1
    logic              r_last_grant;
    logic              r_lock_q;
    logic [HOLD_W-1:0] r_hold_cnt;

    // Read return pipeline
    logic              r_p1_valid;
    logic              r_p1_port;
    logic              r_p1_oor;
    logic              r_rv0;
    logic              r_rv1;
    logic [DATA_W-1:0] r_rd0;
    logic [DATA_W-1:0] r_rd1;
    logic              r_err_oor;

    // Combinational request / grant
    logic              w_req0;
    logic              w_req1;
    logic              w_owner_req;
    logic              w_other_req;
    logic              w_loser_req;
    logic              w_hold_full;
    logic              w_any;
    logic              w_pick;

    // Winner's access
    logic [ADDR_W-1:0] w_win_addr;
    logic              w_win_read;
    logic              w_win_write;
    logic [DATA_W-1:0] w_win_wdata;
    logic [BE_W-1:0]   w_win_be;
    logic              w_win_lock;
    logic              w_oor;
    logic              w_mem_en;
    logic              w_acc_read;

    assign w_req0      = s0_read | s0_write;
    assign w_req1      = s1_read | s1_write;
    assign w_hold_full = (r_hold_cnt >= c_max_hold);

    // Grant selection: starvation cap, then lock, then sole requester, then priority
    always_comb begin
        w_owner_req = r_last_grant ? w_req1 : w_req0;
        w_other_req = r_last_grant ? w_req0 : w_req1;
        w_any       = 1'b0;
        w_pick      = 1'b0;
        if (!reset && (w_req0 || w_req1)) begin
            w_any = 1'b1;
            if (w_hold_full && w_other_req) begin
                w_pick = ~r_last_grant;
            end else if (r_lock_q && w_owner_req) begin
                w_pick = r_last_grant;
            end else if (w_req0 && !w_req1) begin
                w_pick = 1'b0;
            end else if (!w_req0 && w_req1) begin
                w_pick = 1'b1;
            end else if (FIXED_PRI != 0) begin
                w_pick = 1'b0;
            end else begin
                w_pick = ~r_last_grant;
            end
        end
    end

    // Winner mux; a write takes precedence over a simultaneous read
    assign w_win_addr  = w_pick ? s1_address    : s0_address;
    assign w_win_write = w_pick ? s1_write      : s0_write;
    assign w_win_read  = (w_pick ? s1_read      : s0_read) & ~w_win_write;
    assign w_win_wdata = w_pick ? s1_writedata  : s0_writedata;
    assign w_win_be    = w_pick ? s1_byteenable : s0_byteenable;
    assign w_win_lock  = w_pick ? s1_lock       : s0_lock;
    assign w_loser_req = w_pick ? w_req0        : w_req1;

    assign w_oor       = ({1'b0, w_win_addr} >= c_depth_ext);
    assign w_mem_en    = w_any & ~w_oor;
    assign w_acc_read  = w_any & w_win_read;

    assign s0_waitrequest = ~(w_any & ~w_pick) | reset;
    assign s1_waitrequest = ~(w_any &  w_pick) | reset;

    assign mem_address    = w_mem_en ? w_win_addr  : '0;
    assign mem_chipselect = w_mem_en;
    assign mem_write      = w_mem_en & w_win_write;
    assign mem_writedata  = w_mem_en ? w_win_wdata : '0;
    assign mem_byteenable = w_mem_en ? w_win_be    : '0;
    assign mem_clken      = ~reset;

    // Arbitration history: last winner, burst lock and consecutive-grant count
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_grant <= 1'b1;
            r_lock_q     <= 1'b0;
            r_hold_cnt   <= '0;
        end else if (w_any) begin
            r_last_grant <= w_pick;
            r_lock_q     <= w_win_lock;
            if (w_loser_req) begin
                // A change of owner starts a fresh run of one grant
                r_hold_cnt <= (w_pick == r_last_grant) ? r_hold_cnt + HOLD_W'(1) : HOLD_W'(1);
            end else begin
                r_hold_cnt <= '0;
            end
        end else begin
            r_lock_q   <= 1'b0;
            r_hold_cnt <= '0;
        end
    end

    // Stage 1: remember which port a read belongs to while the RAM fetches
    always_ff @(posedge clk) begin
        if (reset) begin
            r_p1_valid <= 1'b0;
            r_p1_port  <= 1'b0;
            r_p1_oor   <= 1'b0;
        end else begin
            r_p1_valid <= w_acc_read;
            r_p1_port  <= w_pick;
            r_p1_oor   <= w_oor;
        end
    end

    // Stage 2: capture RAM data (zero for out-of-range) into the owning port
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rv0 <= 1'b0;
            r_rv1 <= 1'b0;
            r_rd0 <= '0;
            r_rd1 <= '0;
        end else begin
            r_rv0 <= r_p1_valid & ~r_p1_port;
            r_rv1 <= r_p1_valid &  r_p1_port;
            if (r_p1_valid && !r_p1_port) begin
                r_rd0 <= r_p1_oor ? '0 : mem_readdata;
            end
            if (r_p1_valid && r_p1_port) begin
                r_rd1 <= r_p1_oor ? '0 : mem_readdata;
            end
        end
    end

    // Sticky out-of-range flag
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err_oor <= 1'b0;
        end else if (w_any && w_oor) begin
            r_err_oor <= 1'b1;
        end
    end

    assign s0_readdata      = r_rd0;
    assign s0_readdatavalid = r_rv0;
    assign s1_readdata      = r_rd1;
    assign s1_readdatavalid = r_rv1;
    assign err_oor          = r_err_oor;

endmodule
`default_nettype wire

// File: tb/tb_bus_sys_onchip_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_sys_onchip_mem_arbiter
// Purpose  : Directed self-checking bench for the on-chip memory arbiter,
//            with a behavioural RAM model and a fixed-priority second copy.
// Revision : 1.0  initial release
// ============================================================================
module tb_bus_sys_onchip_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;

    logic [15:0] s0_address, s1_address;
    logic        s0_read, s0_write, s0_lock, s1_read, s1_write, s1_lock;
    logic [31:0] s0_writedata, s1_writedata;
    logic [3:0]  s0_byteenable, s1_byteenable;

    logic        s0_waitrequest, s0_readdatavalid, s1_waitrequest, s1_readdatavalid;
    logic [31:0] s0_readdata, s1_readdata;
    logic [15:0] mem_address;
    logic        mem_chipselect, mem_write, mem_clken, err_oor;
    logic [31:0] mem_writedata, mem_readdata;
    logic [3:0]  mem_byteenable;

    logic        fp_s0_waitrequest, fp_s0_readdatavalid, fp_s1_waitrequest, fp_s1_readdatavalid;
    logic [31:0] fp_s0_readdata, fp_s1_readdata;
    logic [15:0] fp_mem_address;
    logic        fp_mem_chipselect, fp_mem_write, fp_mem_clken, fp_err_oor;
    logic [31:0] fp_mem_writedata;
    logic [3:0]  fp_mem_byteenable;
    wire  [31:0] fp_mem_readdata = 32'h0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    bus_sys_onchip_mem_arbiter #(.FIXED_PRI(0), .MAX_HOLD(16)) u_dut (
        .clk(clk), .reset(reset),
        .s0_address(s0_address), .s0_read(s0_read), .s0_write(s0_write),
        .s0_writedata(s0_writedata), .s0_byteenable(s0_byteenable), .s0_lock(s0_lock),
        .s0_waitrequest(s0_waitrequest), .s0_readdata(s0_readdata),
        .s0_readdatavalid(s0_readdatavalid),
        .s1_address(s1_address), .s1_read(s1_read), .s1_write(s1_write),
        .s1_writedata(s1_writedata), .s1_byteenable(s1_byteenable), .s1_lock(s1_lock),
        .s1_waitrequest(s1_waitrequest), .s1_readdata(s1_readdata),
        .s1_readdatavalid(s1_readdatavalid),
        .mem_address(mem_address), .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_byteenable(mem_byteenable),
        .mem_clken(mem_clken), .mem_readdata(mem_readdata), .err_oor(err_oor)
    );

    bus_sys_onchip_mem_arbiter #(.FIXED_PRI(1), .MAX_HOLD(16)) u_fp (
        .clk(clk), .reset(reset),
        .s0_address(s0_address), .s0_read(s0_read), .s0_write(s0_write),
        .s0_writedata(s0_writedata), .s0_byteenable(s0_byteenable), .s0_lock(s0_lock),
        .s0_waitrequest(fp_s0_waitrequest), .s0_readdata(fp_s0_readdata),
        .s0_readdatavalid(fp_s0_readdatavalid),
        .s1_address(s1_address), .s1_read(s1_read), .s1_write(s1_write),
        .s1_writedata(s1_writedata), .s1_byteenable(s1_byteenable), .s1_lock(s1_lock),
        .s1_waitrequest(fp_s1_waitrequest), .s1_readdata(fp_s1_readdata),
        .s1_readdatavalid(fp_s1_readdatavalid),
        .mem_address(fp_mem_address), .mem_chipselect(fp_mem_chipselect),
        .mem_write(fp_mem_write), .mem_writedata(fp_mem_writedata),
        .mem_byteenable(fp_mem_byteenable), .mem_clken(fp_mem_clken),
        .mem_readdata(fp_mem_readdata), .err_oor(fp_err_oor)
    );

    // RAM model: registered-address read; unwritten words read as {D00D, address}
    logic [31:0] ram [logic [15:0]];
    always @(posedge clk) begin
        logic [31:0] word;
        if (mem_clken && mem_chipselect) begin
            word = ram.exists(mem_address) ? ram[mem_address] : {16'hD00D, mem_address};
            if (mem_write) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_byteenable[b]) word[b*8 +: 8] = mem_writedata[b*8 +: 8];
                end
                ram[mem_address] = word;
            end else begin
                mem_readdata <= word;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        s0_address = '0; s0_read = 0; s0_write = 0; s0_writedata = '0; s0_byteenable = '0; s0_lock = 0;
        s1_address = '0; s1_read = 0; s1_write = 0; s1_writedata = '0; s1_byteenable = '0; s1_lock = 0;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        int  i0, i1;
        logic g0, g1;

        mem_readdata = 32'h0;
        idle_inputs();
        reset = 1'b1;
        step();
        step();
        s0_read = 1; s0_address = 16'h0010;
        #1;
        check("rst_wait0", {31'b0, s0_waitrequest}, 32'd1);
        check("rst_wait1", {31'b0, s1_waitrequest}, 32'd1);
        check("rst_clken", {31'b0, mem_clken}, 32'd0);
        check("rst_cs", {31'b0, mem_chipselect}, 32'd0);
        check("rst_err", {31'b0, err_oor}, 32'd0);
        check("rst_rv0", {31'b0, s0_readdatavalid}, 32'd0);
        check("rst_rd0", s0_readdata, 32'h0);
        idle_inputs();
        reset = 1'b0;
        step();

        // Test 1: s0 write then read back
        s0_write = 1; s0_address = 16'h0010; s0_writedata = 32'hA5A5_1234; s0_byteenable = 4'hF;
        #1;
        check("t1_wr_wait0", {31'b0, s0_waitrequest}, 32'd0);
        check("t1_wr_cs", {31'b0, mem_chipselect}, 32'd1);
        check("t1_wr_mw", {31'b0, mem_write}, 32'd1);
        check("t1_wr_addr", {16'b0, mem_address}, 32'h0010);
        check("t1_wr_data", mem_writedata, 32'hA5A5_1234);
        step();
        idle_inputs();
        s0_read = 1; s0_address = 16'h0010;
        #1;
        check("t1_rd_wait0", {31'b0, s0_waitrequest}, 32'd0);
        check("t1_rd_mw", {31'b0, mem_write}, 32'd0);
        step();
        idle_inputs();
        #1;
        check("t1_rv0_early", {31'b0, s0_readdatavalid}, 32'd0);
        step();
        #1;
        check("t1_rv0", {31'b0, s0_readdatavalid}, 32'd1);
        check("t1_rd0", s0_readdata, 32'hA5A5_1234);
        check("t1_rv1", {31'b0, s1_readdatavalid}, 32'd0);
        step();
        #1;
        check("t1_rv0_pulse", {31'b0, s0_readdatavalid}, 32'd0);
        // Seed word 0 for the out-of-range test
        s0_write = 1; s0_address = 16'h0000; s0_writedata = 32'hCAFE_F00D; s0_byteenable = 4'hF;
        step();
        idle_inputs();

        // Test 4: s1 partial byte write at the last valid word
        s1_write = 1; s1_address = 16'h95FF; s1_writedata = 32'h1122_3344; s1_byteenable = 4'hF;
        #1;
        check("t4_wait1", {31'b0, s1_waitrequest}, 32'd0);
        step();
        s1_writedata = 32'hFFFF_FFFF; s1_byteenable = 4'b0101;
        #1;
        check("t4_be", {28'b0, mem_byteenable}, 32'h5);
        step();
        idle_inputs();
        s1_read = 1; s1_address = 16'h95FF;
        step();
        idle_inputs();
        step();
        #1;
        check("t4_rv1", {31'b0, s1_readdatavalid}, 32'd1);
        check("t4_rd1", s1_readdata, 32'h11FF_33FF);

        // Test 5: out-of-range write and read at DEPTH
        step();
        s0_write = 1; s0_address = 16'h9600; s0_writedata = 32'h1234_5678; s0_byteenable = 4'hF;
        #1;
        check("t5_wr_wait0", {31'b0, s0_waitrequest}, 32'd0);
        check("t5_wr_cs", {31'b0, mem_chipselect}, 32'd0);
        check("t5_wr_mw", {31'b0, mem_write}, 32'd0);
        check("t5_wr_addr", {16'b0, mem_address}, 32'h0);
        check("t5_err_before", {31'b0, err_oor}, 32'd0);
        step();
        idle_inputs();
        s0_read = 1; s0_address = 16'h9600;
        #1;
        check("t5_err_set", {31'b0, err_oor}, 32'd1);
        check("t5_rd_wait0", {31'b0, s0_waitrequest}, 32'd0);
        check("t5_rd_cs", {31'b0, mem_chipselect}, 32'd0);
        step();
        idle_inputs();
        step();
        #1;
        check("t5_rv0", {31'b0, s0_readdatavalid}, 32'd1);
        check("t5_rd0", s0_readdata, 32'h0);
        step();
        step();
        s0_read = 1; s0_address = 16'h0000;
        #1;
        check("t5_err_sticky", {31'b0, err_oor}, 32'd1);
        step();
        idle_inputs();
        step();
        #1;
        check("t5_ram0", s0_readdata, 32'hCAFE_F00D);

        // Test 6: reset one cycle after an s1 read accept discards it
        step();
        s1_read = 1; s1_address = 16'h0300;
        #1;
        check("t6_wait1", {31'b0, s1_waitrequest}, 32'd0);
        step();
        idle_inputs();
        reset = 1'b1;
        #1;
        check("t6_rst_clken", {31'b0, mem_clken}, 32'd0);
        step();
        reset = 1'b0;
        #1;
        check("t6_rv1_a", {31'b0, s1_readdatavalid}, 32'd0);
        check("t6_err_clr", {31'b0, err_oor}, 32'd0);
        step();
        #1;
        check("t6_rv1_b", {31'b0, s1_readdatavalid}, 32'd0);

        // Test 2 (continuing from reset): alternating continuous reads
        i0 = 0;
        i1 = 0;
        for (int k = 0; k < 12; k++) begin
            s0_read = 1; s0_address = 16'h0100 + 16'(i0);
            s1_read = 1; s1_address = 16'h0200 + 16'(i1);
            #1;
            g0 = (k % 2 == 0);
            check($sformatf("t2_wait0_%0d", k), {31'b0, s0_waitrequest}, {31'b0, !g0});
            check($sformatf("t2_wait1_%0d", k), {31'b0, s1_waitrequest}, {31'b0, g0});
            check($sformatf("t2_fp_wait0_%0d", k), {31'b0, fp_s0_waitrequest}, 32'd0);
            check($sformatf("t2_rv0_%0d", k), {31'b0, s0_readdatavalid},
                  {31'b0, (k >= 2 && k % 2 == 0)});
            check($sformatf("t2_rv1_%0d", k), {31'b0, s1_readdatavalid},
                  {31'b0, (k >= 3 && k % 2 == 1)});
            if (k >= 2 && k % 2 == 0)
                check($sformatf("t2_rd0_%0d", k), s0_readdata, {16'hD00D, 16'h0100 + 16'((k - 2) / 2)});
            if (k >= 3 && k % 2 == 1)
                check($sformatf("t2_rd1_%0d", k), s1_readdata, {16'hD00D, 16'h0200 + 16'((k - 3) / 2)});
            if (g0) i0++;
            else    i1++;
            step();
        end
        idle_inputs();

        // Test 3: s0 locked burst vs s1, starvation cap of 16 in both arbiters
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int k = 0; k < 40; k++) begin
            s0_read = 1; s0_lock = 1; s0_address = 16'h0400;
            s1_read = 1; s1_address = 16'h0500;
            #1;
            g1 = (k % 17 == 16);
            check($sformatf("t3_wait1_%0d", k), {31'b0, s1_waitrequest}, {31'b0, !g1});
            check($sformatf("t3_wait0_%0d", k), {31'b0, s0_waitrequest}, {31'b0, g1});
            check($sformatf("t3_fp_wait1_%0d", k), {31'b0, fp_s1_waitrequest}, {31'b0, !g1});
            step();
        end
        idle_inputs();
        step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Watchdog so the run always terminates
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
